sha3_squeeze_unit: RTL
======================

Name: sha3_squeeze_unit

Overview:
Read-side counterpart of the Keccak permutation datapath. It captures the 1600-bit state when a permutation completes, then streams the digest out as W_WIDTH-bit words over a valid/ready handshake. When the digest is longer than the rate (SHAKE-style output), it requests further permutations. It sits between the permutation module's state output and the core's result interface.

Parameters:
R_BLOCK_SIZE, 1088, rate in bits; must be a multiple of W_WIDTH and at most 1600.
D_WIDTH, 256, total digest length in bits; must be at least 1.
W_WIDTH, 64, output word width in bits.

Ports:
CLK  in  1  rising-edge clock.
A_RST  in  1  synchronous, active-high reset.
STATE_IN  in  [0:1599]  permutation state; bit 0 is the first state bit.
STATE_VALID  in  1  one-cycle pulse: STATE_IN holds a completed permutation result.
OUT_WORD  out  [0:W_WIDTH-1]  current digest word.
OUT_VALID  out  1  OUT_WORD is valid.
OUT_READY  in  1  downstream accepts OUT_WORD.
OUT_LAST  out  1  OUT_WORD is the final digest word.
PERM_REQ  out  1  one-cycle pulse requesting another permutation of the current state.
BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (A_RST sampled high at a CLK edge):
  - state becomes IDLE; all outputs become 0, including OUT_WORD.
  - the word counter and the rate counter clear.
  - reset wins over every other input in the same cycle, including mid-stream or mid-WAIT_PERM.
- Derived constants:
  - NWORDS = ceil(D_WIDTH/W_WIDTH).
  - RWORDS = R_BLOCK_SIZE/W_WIDTH.
  - PAD = NWORDS*W_WIDTH - D_WIDTH.
- State machine: IDLE, EMIT, REQ, WAIT_PERM.
- IDLE:
  - On STATE_VALID=1, register STATE_IN[0:R_BLOCK_SIZE-1] into the shift buffer.
  - Clear the word counter (wcnt) and the rate counter (rcnt). Go to EMIT.
  - OUT_VALID rises on the next cycle, so latency from STATE_VALID to the first OUT_VALID is 1 cycle.
- EMIT:
  - OUT_VALID=1; OUT_WORD = buffer[0:W_WIDTH-1].
  - A transfer occurs when OUT_VALID and OUT_READY are both high.
  - OUT_WORD must stay stable while OUT_READY is low.
  - On each transfer:
    - shift the buffer left by W_WIDTH; increment wcnt and rcnt.
    - if wcnt == NWORDS-1 (the last word), go to IDLE.
    - else if rcnt == RWORDS-1 (rate exhausted), go to REQ.
    - otherwise stay in EMIT; back-to-back transfers give one word per cycle.
- OUT_LAST = OUT_VALID and (wcnt == NWORDS-1).
- Final partial word: if PAD > 0, the last PAD bits of the final OUT_WORD (highest indices) are forced to 0.
- REQ:
  - PERM_REQ=1 for exactly one cycle, OUT_VALID=0. Next state is WAIT_PERM.
- WAIT_PERM:
  - OUT_VALID=0; wait for STATE_VALID.
  - On STATE_VALID, reload the buffer from STATE_IN[0:R_BLOCK_SIZE-1], clear rcnt (wcnt is kept), and go to EMIT.
- STATE_VALID is ignored in EMIT and REQ; the buffer is not overwritten.
- STATE_VALID arriving in the same cycle as PERM_REQ is ignored; only a pulse seen in WAIT_PERM counts.
- If D_WIDTH <= R_BLOCK_SIZE, REQ is never entered and PERM_REQ stays 0.
- OUT_READY held at 0 indefinitely: the unit holds its state and word with no timeout.

Optional Feature:
SHA3_SQUEEZE_BYTE_SWAP_EN.
- Defined: each OUT_WORD has its bytes reversed before output (byte 0 of the lane appears in OUT_WORD[W_WIDTH-8:W_WIDTH-1]). This converts Keccak little-endian lanes to big-endian digest byte order. PAD masking is applied after the swap. W_WIDTH must be a multiple of 8.
- Not defined: the word is passed through unswapped, with no extra logic.

Test Plan:
1. Defaults, STATE_IN lane k = 64'h1111_1111_1111_1111*(k+1), STATE_VALID pulse, OUT_READY=1 -> four words 1111..., 2222..., 3333..., 4444... on consecutive cycles, first one cycle after STATE_VALID; OUT_LAST only on the 4th; BUSY drops the cycle after; PERM_REQ never asserted.
2. OUT_READY toggles 1,0,0,1,0,1,1 -> exactly four transfers, in order, with OUT_WORD stable during stalls and no duplicated or lost words.
3. R_BLOCK_SIZE=128, D_WIDTH=320 (5 words) -> 2 words, PERM_REQ pulse, wait; new state pulse after 10 cycles -> 2 words, PERM_REQ, new pulse -> 1 word with OUT_LAST=1; exactly 2 PERM_REQ pulses total.
4. D_WIDTH=224, all-ones state -> 4th word = 64'hFFFF_FFFF_0000_0000 with OUT_LAST=1.
5. A_RST asserted while the 2nd word is stalled -> next cycle OUT_VALID=0, BUSY=0, OUT_WORD=0; a fresh STATE_VALID restarts from word 0.
6. With SHA3_SQUEEZE_BYTE_SWAP_EN, lane 0 = 64'h0102030405060708 -> first OUT_WORD = 64'h0807060504030201.

Source files
------------

// File: rtl/sha3_squeeze_unit.sv
// Squeeze stage: captures the rate part of a Keccak state and streams the digest as W_WIDTH-bit words,
// requesting extra permutations for long outputs. Macro SHA3_SQUEEZE_BYTE_SWAP_EN reverses bytes per word.
module sha3_squeeze_unit #(
   parameter int R_BLOCK_SIZE = 1088,
   parameter int D_WIDTH      = 256,
   parameter int W_WIDTH      = 64
) (
   input  logic                 CLK,
   input  logic                 A_RST,
   input  logic [0:1599]        STATE_IN,
   input  logic                 STATE_VALID,
   output logic [0:W_WIDTH-1]   OUT_WORD,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic                 OUT_LAST,
   output logic                 PERM_REQ,
   output logic                 BUSY
);

   localparam int NWORDS = (D_WIDTH + W_WIDTH - 1) / W_WIDTH;
   localparam int RWORDS = R_BLOCK_SIZE / W_WIDTH;
   localparam int PAD    = NWORDS * W_WIDTH - D_WIDTH;
   localparam int WC_W   = $clog2(NWORDS + 1);
   localparam int RC_W   = $clog2(RWORDS + 1);

   localparam logic [WC_W-1:0]    LAST_WCNT = WC_W'(NWORDS - 1);
   localparam logic [RC_W-1:0]    LAST_RCNT = RC_W'(RWORDS - 1);
   // Clears the trailing PAD bits (highest indices) of the final word.
   localparam logic [0:W_WIDTH-1] LAST_MASK = {W_WIDTH{1'b1}} << PAD;

   typedef enum logic [1:0] {IDLE, EMIT, REQ, WAIT_PERM} state_t;

   state_t                  state_q, state_d;
   logic [0:R_BLOCK_SIZE-1] sbuf_q, sbuf_d;
   logic [WC_W-1:0]         wcnt_q, wcnt_d;
   logic [RC_W-1:0]         rcnt_q, rcnt_d;
   logic [0:W_WIDTH-1]      out_word_q, out_word_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    perm_req_q, perm_req_d;
   logic                    busy_q, busy_d;
   logic [0:W_WIDTH-1]      head_word;
   logic [0:W_WIDTH-1]      lane_word;

   always_comb begin
      state_d = state_q;
      sbuf_d  = sbuf_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      unique case (state_q)
         IDLE: begin
            if (STATE_VALID) begin
               sbuf_d  = STATE_IN[0:R_BLOCK_SIZE-1];
               wcnt_d  = '0;
               rcnt_d  = '0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            // OUT_VALID is always high here, so OUT_READY alone marks a transfer.
            if (OUT_READY) begin
               sbuf_d = sbuf_q << W_WIDTH;
               wcnt_d = wcnt_q + WC_W'(1);
               rcnt_d = rcnt_q + RC_W'(1);
               if (wcnt_q == LAST_WCNT) begin
                  state_d = IDLE;
               end else if (rcnt_q == LAST_RCNT) begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            state_d = WAIT_PERM;
         end
         WAIT_PERM: begin
            if (STATE_VALID) begin
               sbuf_d  = STATE_IN[0:R_BLOCK_SIZE-1];
               rcnt_d  = '0;
               state_d = EMIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign head_word = sbuf_d[0:W_WIDTH-1];

`ifdef SHA3_SQUEEZE_BYTE_SWAP_EN
   generate
      for (genvar gi = 0; gi < W_WIDTH / 8; gi++) begin : g_swap
         assign lane_word[gi*8 +: 8] = head_word[(W_WIDTH/8 - 1 - gi)*8 +: 8];
      end
   endgenerate
`else
   assign lane_word = head_word;
`endif

   // Outputs are registered from the next-state view so they line up with state_q.
   always_comb begin
      out_valid_d = (state_d == EMIT);
      out_last_d  = out_valid_d && (wcnt_d == LAST_WCNT);
      out_word_d  = '0;
      if (out_valid_d) begin
         out_word_d = out_last_d ? (lane_word & LAST_MASK) : lane_word;
      end
      perm_req_d  = (state_d == REQ);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (A_RST) begin
         state_q     <= IDLE;
         sbuf_q      <= '0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         out_word_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         perm_req_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sbuf_q      <= sbuf_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         perm_req_q  <= perm_req_d;
         busy_q      <= busy_d;
      end
   end

   generate
      if (R_BLOCK_SIZE < 1600) begin : g_capacity
         logic unused_capacity_bits;
         assign unused_capacity_bits = ^STATE_IN[R_BLOCK_SIZE:1599];
      end
   endgenerate

   assign OUT_WORD  = out_word_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_LAST  = out_last_q;
   assign PERM_REQ  = perm_req_q;
   assign BUSY      = busy_q;

endmodule
